mem_access: RTL and testbench

//  Memory-stage data-RAM access unit, directly downstream of the EX/MEM register.

---
 rtl/mem_access.sv | 111 +++++++++++
 tb/tb_mem_access.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM-stage data-RAM access unit (alignment check, req/addr_ok/data_ok bus, load formatting)
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   ex_pc                 pc of the instruction in MEM (informational only)
//   ex_alu_out            effective byte address
//   ex_rdata2             store data
//   ex_is_ram/ex_ram_we   load/store valid, 1=store
//   ex_ram_wen            size code 0001 byte, 0011 half, 1111 word
//   ex_ram_sign           bit0 sign-extends loads
//   ex_cp0_ex             upstream exception pending, suppresses the access
//   int_flush             pipeline flush
//   data_sram_*           SRAM-like request/response bus
//   mem_stall             holds EX/MEM and upstream while an access is in flight
//   mem_load_data         formatted load result
//   memory_cp0_*          address-error report (excode, faulting address)
module mem_access #(
  parameter logic [4:0] EXC_ADEL = 5'h04,
  parameter logic [4:0] EXC_ADES = 5'h05
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rdata2,
  input  logic        ex_is_ram,
  input  logic        ex_ram_we,
  input  logic [3:0]  ex_ram_wen,
  input  logic [1:0]  ex_ram_sign,
  input  logic        ex_cp0_ex,
  input  logic        int_flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic        memory_cp0_ex,
  output logic [4:0]  memory_cp0_excode,
  output logic [31:0] memory_cp0_badvaddr
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_half, is_word, misalign, start;
  logic [1:0]  size_c;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c, ld_src;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sg;
  logic        pc_unused;
  assign pc_unused = ^{ex_pc, ex_ram_sign[1]};
  assign is_half  = ex_ram_wen == 4'b0011;
  assign is_word  = ex_ram_wen == 4'b1111;
  assign misalign = (is_half & ex_alu_out[0]) | (is_word & (ex_alu_out[1:0] != 2'b00));
  assign start    = ex_is_ram & ~ex_cp0_ex & ~misalign & ~int_flush;
  assign size_c  = is_word ? 2'd2 : is_half ? 2'd1 : 2'd0;
  assign wstrb_c = is_word ? 4'b1111 : is_half ? (ex_alu_out[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ex_alu_out[1:0];
  assign wdata_c = is_word ? ex_rdata2 : is_half ? {2{ex_rdata2[15:0]}} : {4{ex_rdata2[7:0]}};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end
  // A flushed access that was already accepted must still see its data_ok before the bus is free again.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE:  state_d = start ? REQ : IDLE;
      REQ:   state_d = data_sram_addr_ok ? (int_flush ? DRAIN : WAIT) : (int_flush ? IDLE : REQ);
      WAIT:  state_d = data_sram_data_ok ? IDLE : (int_flush ? DRAIN : WAIT);
      DRAIN: state_d = data_sram_data_ok ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    rdata_d = (state_q == WAIT && data_sram_data_ok && !int_flush) ? data_sram_rdata : rdata_q;
  end
  always_comb begin
    data_sram_req   = state_q == REQ;
    data_sram_wr    = data_sram_req & ex_ram_we;
    data_sram_size  = data_sram_req ? size_c : 2'd0;
    data_sram_addr  = data_sram_req ? ex_alu_out : 32'd0;
    data_sram_wstrb = data_sram_wr ? wstrb_c : 4'd0;
    data_sram_wdata = data_sram_wr ? wdata_c : 32'd0;
    mem_stall       = (state_q == IDLE & start) | (state_q == REQ) |
                      (state_q == WAIT & ~data_sram_data_ok) | (state_q == DRAIN & start);
  end
  // Load data is taken straight off the bus in the data_ok cycle so the pipeline can advance at that edge.
  assign ld_src  = data_sram_data_ok ? data_sram_rdata : rdata_q;
  assign ld_byte = ex_alu_out[1] ? (ex_alu_out[0] ? ld_src[31:24] : ld_src[23:16])
                                 : (ex_alu_out[0] ? ld_src[15:8]  : ld_src[7:0]);
  assign ld_half = ex_alu_out[1] ? ld_src[31:16] : ld_src[15:0];
  assign sg      = ex_ram_sign[0];
  assign mem_load_data = !(ex_is_ram & ~ex_ram_we) ? 32'd0 :
                         is_word ? ld_src :
                         is_half ? {{16{sg & ld_half[15]}}, ld_half} :
                                   {{24{sg & ld_byte[7]}}, ld_byte};
  assign memory_cp0_ex       = ex_is_ram & misalign & ~ex_cp0_ex;
  assign memory_cp0_excode   = memory_cp0_ex ? (ex_ram_we ? EXC_ADES : EXC_ADEL) : 5'd0;
  assign memory_cp0_badvaddr = memory_cp0_ex ? ex_alu_out : 32'd0;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scoreboard bench for mem_access
module tb_mem_access;
  logic clk = 0, reset = 1;
  logic [31:0] ex_pc = 0, ex_alu_out = 0, ex_rdata2 = 0;
  logic ex_is_ram = 0, ex_ram_we = 0, ex_cp0_ex = 0, int_flush = 0;
  logic [3:0] ex_ram_wen = 0;
  logic [1:0] ex_ram_sign = 0;
  logic data_sram_req, data_sram_wr, data_sram_addr_ok = 0, data_sram_data_ok = 0;
  logic [1:0] data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata = 0;
  logic [3:0] data_sram_wstrb;
  logic mem_stall, memory_cp0_ex;
  logic [31:0] mem_load_data, memory_cp0_badvaddr;
  logic [4:0] memory_cp0_excode;
  int total = 0, bad = 0, stall_cyc = 0;
  typedef struct {logic wr; logic [1:0] size; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} req_t;
  typedef struct {logic we; logic [3:0] wen; logic sg; logic [31:0] addr, wd, rd; int al, dl;
                  logic [1:0] esize; logic [3:0] ewstrb; logic [31:0] ewdata, eld;} vec_t;
  req_t req_q[$];
  logic [31:0] resp_q[$];
  vec_t tv[11];
  mem_access dut (
    .clk(clk), .reset(reset), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out), .ex_rdata2(ex_rdata2),
    .ex_is_ram(ex_is_ram), .ex_ram_we(ex_ram_we), .ex_ram_wen(ex_ram_wen), .ex_ram_sign(ex_ram_sign),
    .ex_cp0_ex(ex_cp0_ex), .int_flush(int_flush), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .mem_stall(mem_stall), .mem_load_data(mem_load_data),
    .memory_cp0_ex(memory_cp0_ex), .memory_cp0_excode(memory_cp0_excode), .memory_cp0_badvaddr(memory_cp0_badvaddr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  logic tb_mis, tb_start;
  assign tb_mis   = (ex_ram_wen == 4'b0011 && ex_alu_out[0]) || (ex_ram_wen == 4'b1111 && ex_alu_out[1:0] != 2'b00);
  assign tb_start = ex_is_ram && !ex_cp0_ex && !tb_mis && !int_flush;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_stall) stall_cyc++;
      if (data_sram_req && data_sram_addr_ok) begin
        if (req_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
        else begin : pop_req
          req_t e;
          e = req_q.pop_front();
          chk("req_addr", data_sram_addr, e.addr);
          chk("req_wr_size_wstrb", {data_sram_wr, data_sram_size, data_sram_wstrb}, {e.wr, e.size, e.wstrb});
          if (e.wr) chk("req_wdata", data_sram_wdata, e.wdata);
        end
      end
      if (tb_start && !mem_stall) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else chk("load_data", mem_load_data, resp_q.pop_front());
      end
    end
  end
  task automatic set_ex(input logic we, input logic [3:0] wen, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    ex_is_ram = 1; ex_ram_we = we; ex_ram_wen = wen; ex_ram_sign = {1'b0, sg}; ex_alu_out = a; ex_rdata2 = wd;
  endtask
  task automatic op(input vec_t v);
    set_ex(v.we, v.wen, v.sg, v.addr, v.wd);
    req_q.push_back('{v.we, v.esize, v.addr, v.ewstrb, v.ewdata});
    resp_q.push_back(v.eld);
    stall_cyc = 0;
    tick;
    for (int i = 0; i < v.al; i++) begin
      chk("req_held", data_sram_req, 1);
      chk("addr_stable", data_sram_addr, v.addr);
      chk("stall_in_req", mem_stall, 1);
      tick;
    end
    data_sram_addr_ok = 1;
    tick;
    data_sram_addr_ok = 0;
    repeat (v.dl) tick;
    data_sram_data_ok = 1; data_sram_rdata = v.rd;
    tick;
    data_sram_data_ok = 0; ex_is_ram = 0;
    chk("stall_cycles", stall_cyc, 2 + v.al + v.dl);
  endtask
  initial begin
    tv[0]  = '{0, 4'hF, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 2'd2, 4'h0, 32'h0, 32'hDEADBEEF};
    tv[1]  = '{0, 4'h1, 1, 32'h103, 32'h0, 32'h80FFFF7F, 1, 0, 2'd0, 4'h0, 32'h0, 32'hFFFFFF80};
    tv[2]  = '{0, 4'h1, 0, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1, 2'd0, 4'h0, 32'h0, 32'h00000080};
    tv[3]  = '{0, 4'h3, 1, 32'h102, 32'h0, 32'h80FFFF7F, 0, 2, 2'd1, 4'h0, 32'h0, 32'hFFFF80FF};
    tv[4]  = '{0, 4'h3, 0, 32'h100, 32'h0, 32'h80FFFF7F, 0, 0, 2'd1, 4'h0, 32'h0, 32'h0000FF7F};
    tv[5]  = '{0, 4'h1, 1, 32'h100, 32'h0, 32'h80FFFF7F, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0000007F};
    tv[6]  = '{1, 4'h3, 0, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0, 0, 2'd1, 4'hC, 32'hABCDABCD, 32'h0};
    tv[7]  = '{1, 4'h1, 0, 32'h101, 32'h000000AB, 32'hFFFFFFFF, 2, 0, 2'd0, 4'h2, 32'hABABABAB, 32'h0};
    tv[8]  = '{1, 4'hF, 0, 32'h104, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1, 2'd2, 4'hF, 32'hCAFEF00D, 32'h0};
    tv[9]  = '{0, 4'hF, 0, 32'h108, 32'h0, 32'h13579BDF, 5, 1, 2'd2, 4'h0, 32'h0, 32'h13579BDF};
    tv[10] = '{0, 4'hF, 0, 32'h300, 32'h0, 32'h22222222, 0, 0, 2'd2, 4'h0, 32'h0, 32'h22222222};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_wr_size_wstrb", {data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb}, 0);
    chk("rst_addr", data_sram_addr, 0);
    chk("rst_wdata", data_sram_wdata, 0);
    chk("rst_stall_ex_code", {mem_stall, memory_cp0_ex, memory_cp0_excode}, 0);
    chk("rst_badvaddr", memory_cp0_badvaddr, 0);
    chk("rst_load_data", mem_load_data, 0);
    reset = 0;
    tick;
    for (int i = 0; i < 10; i++) op(tv[i]);
    // address errors
    set_ex(0, 4'hF, 0, 32'h101, 0);
    #2;
    chk("adel_ex", memory_cp0_ex, 1);
    chk("adel_code", memory_cp0_excode, 5'h04);
    chk("adel_badvaddr", memory_cp0_badvaddr, 32'h101);
    chk("adel_no_stall", mem_stall, 0);
    tick;
    chk("adel_no_req", data_sram_req, 0);
    set_ex(1, 4'hF, 0, 32'h102, 32'h55);
    #2;
    chk("ades_ex", memory_cp0_ex, 1);
    chk("ades_code", memory_cp0_excode, 5'h05);
    set_ex(0, 4'h3, 1, 32'h101, 0);
    #2;
    chk("adel_half_code", memory_cp0_excode, 5'h04);
    ex_cp0_ex = 1;
    set_ex(0, 4'hF, 0, 32'h101, 0);
    #2;
    chk("suppressed_ex", {memory_cp0_ex, mem_stall}, 0);
    tick;
    chk("suppressed_no_req", data_sram_req, 0);
    ex_cp0_ex = 0; ex_is_ram = 0;
    tick;
    // flush in REQ without addr_ok withdraws the request
    set_ex(0, 4'hF, 0, 32'h400, 0);
    tick;
    int_flush = 1;
    #1 chk("flush_req_still_req", data_sram_req, 1);
    tick;
    int_flush = 0; ex_is_ram = 0;
    chk("flush_req_withdrawn", {data_sram_req, mem_stall}, 0);
    tick;
    // flush in WAIT, data_ok three cycles later, new load waits for the drain
    set_ex(0, 4'hF, 0, 32'h200, 0);
    req_q.push_back('{1'b0, 2'd2, 32'h200, 4'h0, 32'h0});
    tick;
    data_sram_addr_ok = 1;
    tick;
    data_sram_addr_ok = 0; int_flush = 1;
    #1 chk("flush_wait_stall", mem_stall, 1);
    tick;
    int_flush = 0; ex_is_ram = 0;
    chk("drain_idle_no_stall", mem_stall, 0);
    set_ex(0, 4'hF, 0, 32'h300, 0);
    #1 chk("drain_new_op_stalled", {mem_stall, data_sram_req}, 2'b10);
    tick;
    chk("drain_still_stalled", {mem_stall, data_sram_req}, 2'b10);
    tick;
    data_sram_data_ok = 1; data_sram_rdata = 32'h11111111;
    #1 chk("drain_data_ok_stall", mem_stall, 1);
    tick;
    data_sram_data_ok = 0; ex_cp0_ex = 1;
    #1 chk("discarded_data_not_kept", mem_load_data, 32'h13579BDF);
    ex_cp0_ex = 0;
    op(tv[10]);
    // asynchronous reset in the middle of REQ
    set_ex(0, 4'hF, 0, 32'h700, 0);
    tick;
    chk("pre_reset_req", data_sram_req, 1);
    #1 reset = 1; ex_is_ram = 0;
    #1 chk("reset_mid_req", {data_sram_req, mem_stall}, 0);
    chk("reset_mid_req_addr", data_sram_addr, 0);
    tick;
    reset = 0;
    tick;
    chk("req_queue_empty", req_q.size(), 0);
    chk("resp_queue_empty", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
